ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 200000, which is the clk cycles allowed between PS/2 clock falling edges inside a frame (2 ms at 100 MHz).
REQ-002 SHALL have port clk  input  1  system clock (100 MHz); all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ps2_clk  input  1  raw PS/2 clock, asynchronous to clk.
REQ-005 SHALL have port ps2_data  input  1  raw PS/2 data, asynchronous to clk.
REQ-006 SHALL have ports up, down, left, right  output  1 each  held key state, 1 while the arrow key is pressed.
REQ-007 SHALL have port enter  output  1  held state of the Enter key.
REQ-008 SHALL have port fire  output  1  held state of the Space key.
REQ-009 SHALL have port scan_valid  output  1  one-cycle pulse when a good byte is received.
REQ-010 SHALL have port scan_code  output  8  last good byte received; valid when scan_valid is 1.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on a parity error, a stop-bit error or a timeout.

Function
REQ-012 SHALL pass ps2_clk and ps2_data each through a 2-flop synchroniser, then a third flop on ps2_clk for edge detection; a falling edge is synced==0 while delayed==1.
REQ-013 SHALL run a frame FSM with states IDLE, DATA, PARITY and STOP, advancing only on a detected falling edge.
REQ-014 SHALL, in IDLE, move to DATA when the sampled data is 0 (start bit), and stay in IDLE with no error when it is 1.
REQ-015 SHALL, in DATA, shift 8 bits LSB first using a 3-bit counter, then move to PARITY after bit 7.
REQ-016 SHALL, in PARITY, sample the parity bit, then move to STOP; the frame is good when data XOR parity gives odd parity.
REQ-017 SHALL, in STOP, accept the byte when stop==1 and parity is good; otherwise it pulses frame_err; in both cases it returns to IDLE.
REQ-018 SHALL, for an accepted byte, assert scan_valid and update scan_code in the clk cycle after the stop-bit edge is detected.
REQ-019 SHALL update key outputs in that same cycle.
REQ-020 SHALL clear the timeout counter on every falling edge and count otherwise while not in IDLE.
REQ-021 SHALL, when the timeout counter reaches TIMEOUT_CYCLES-1, return to IDLE, pulse frame_err, discard the partial byte and clear the ext and brk flags.
REQ-022 SHALL, for an accepted byte 0xE0, set the ext flag; for 0xF0, set the brk flag; neither changes key outputs; scan_valid still pulses.
REQ-023 SHALL, for any other accepted byte, apply the key map below, setting the matched key to NOT brk, then clear ext and brk.
REQ-024 SHALL use this key map: with ext=1, 0x75 is up, 0x72 is down, 0x6B is left and 0x74 is right; 0x5A is enter regardless of ext; 0x29 is fire with ext=0.
REQ-025 SHALL leave all keys unchanged for an unmatched code, and still clear the flags.
REQ-026 SHALL leave a held key at 1 on a repeated make code (typematic repeat); it is not toggled.
REQ-027 SHALL, when a frame error occurs, also clear ext and brk; held key outputs keep their values.
REQ-028 SHALL allow any number of keys to be held at the same time; each key's output is independent.
REQ-029 SHALL drive all outputs from registers; there is no combinational path from ps2 inputs to outputs.

Reset
REQ-030 SHALL, on rst, clear up, down, left, right, enter, fire, scan_valid, scan_code (0x00) and frame_err to 0.
REQ-031 SHALL, on rst, put the FSM in IDLE and clear the flags, the shift register, the bit counter and the timeout counter.
REQ-032 SHALL, when rst is asserted mid-frame, abort the frame with no scan_valid or frame_err pulse; the next frame is decoded normally after release.
REQ-033 SHALL preset the synchroniser flops to 1 (the idle bus level), so no false edge appears at reset release.

Structure
REQ-034 SHALL place the scan-code constants (E0, F0, 75, 72, 6B, 74, 5A, 29), the FSM state enumeration and the TIMEOUT_CYCLES default in shared package ps2_pkg.
REQ-035 SHALL split the frame receiver into sub-module ps2_rx_frame, covering synchroniser, FSM and timeout, with outputs byte, byte_valid and frame_err.
REQ-036 SHALL keep the prefix flags and key map in ps2_key_decoder.

Verification
REQ-037 SHALL cover: frame 0x5A, good parity -> scan_valid pulse one cycle after the stop edge, scan_code=0x5A, enter=1; then F0,5A -> enter=0.
REQ-038 SHALL cover: E0,75 then E0,6B -> up=1 and left=1 together; E0,F0,75 -> up=0 and left stays 1.
REQ-039 SHALL cover: frame 0x29 with the parity bit inverted -> frame_err pulse, no scan_valid, fire stays 0.
REQ-040 SHALL cover: 4 data bits then the clock stops -> frame_err exactly TIMEOUT_CYCLES cycles after the last edge; a following good 0x72 frame decodes with ext=0, so down stays 0.
REQ-041 SHALL cover: rst pulse during bit 5 of a frame -> all outputs 0, no pulses; a following E0,72 -> down=1.
REQ-042 SHALL cover: 0x75 without the E0 prefix -> scan_valid pulses, up stays 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, types and helpers for the PS/2 keyboard decoder
package ps2_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 200000;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_FIRE  = 8'h29;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic enter;
    logic fire;
  } keys_t;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 frame receiver: synchroniser, frame FSM and inter-edge timeout
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic clk_meta, clk_sync, clk_dly;
  logic data_meta, data_sync;
  logic fall;

  rx_state_t     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_hit;

  // Preset to the idle bus level so reset release never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_dly   <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_dly   <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  assign fall = ~clk_sync & clk_dly;

  // A late-arriving edge on the last count still wins over the timeout.
  assign timeout_hit = (state_q != ST_IDLE) && !fall && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;

    if (state_q == ST_IDLE || fall) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    if (timeout_hit) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      to_cnt_d  = '0;
      frame_err = 1'b1;
    end else if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_sync) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_sync, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_d = data_sync;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (data_sync && odd_parity_ok(shift_q, parity_q)) begin
            byte_valid = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign byte_data = shift_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard decoder: E0/F0 prefix tracking and held-key map
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       enter,
  output logic       fire,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  keys_t keys_q, keys_d;
  logic  ext_q, ext_d;
  logic  brk_q, brk_d;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_data (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_err)
  );

  // Receiver strobes are combinational, so registering them here keeps the
  // key update, scan_valid and scan_code all in the same cycle.
  always_comb begin
    keys_d = keys_q;
    ext_d  = ext_q;
    brk_d  = brk_q;

    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        if (ext_q) begin
          case (rx_byte)
            SC_UP:    keys_d.up    = !brk_q;
            SC_DOWN:  keys_d.down  = !brk_q;
            SC_LEFT:  keys_d.left  = !brk_q;
            SC_RIGHT: keys_d.right = !brk_q;
            default:  ;
          endcase
        end else if (rx_byte == SC_FIRE) begin
          keys_d.fire = !brk_q;
        end
        if (rx_byte == SC_ENTER) begin
          keys_d.enter = !brk_q;
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      scan_valid <= 1'b0;
      scan_code  <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      keys_q     <= keys_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      scan_valid <= rx_valid;
      frame_err  <= rx_err;
      if (rx_valid) begin
        scan_code <= rx_byte;
      end
    end
  end

  assign up    = keys_q.up;
  assign down  = keys_q.down;
  assign left  = keys_q.left;
  assign right = keys_q.right;
  assign enter = keys_q.enter;
  assign fire  = keys_q.fire;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - scoreboard bench for ps2_key_decoder
module tb_ps2_key_decoder;

  localparam int T = 100;
  localparam int H = 8;
  // ps2_clk drive -> 2 sync flops -> edge consumed: outputs appear 3 clk edges later
  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       up, down, left, right, enter, fire;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       frame_err;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    logic [5:0] keys;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   last_fall_cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .enter     (enter),
    .fire      (fire),
    .scan_valid(scan_valid),
    .scan_code (scan_code),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] keys_now();
    return {up, down, left, right, enter, fire};
  endfunction

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   lat;
    if (!rst && (scan_valid || frame_err)) begin
      n_cmp++;
      lat = cyc - last_fall_cyc;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: got scan_valid=%b frame_err=%b code=%02h, wanted no pulse",
                 scan_valid, frame_err, scan_code);
      end else begin
        e = sb.pop_front();
        if (frame_err != e.is_err || scan_valid == e.is_err ||
            (!e.is_err && scan_code != e.code) || keys_now() != e.keys || lat != e.lat) begin
          n_bad++;
          $display("FAIL pulse: got err=%b valid=%b code=%02h keys=%06b lat=%0d, wanted err=%b code=%02h keys=%06b lat=%0d",
                   frame_err, scan_valid, scan_code, keys_now(), lat,
                   e.is_err, e.code, e.keys, e.lat);
        end
      end
    end
  end

  task automatic ps2_bit(input logic b);
    repeat (H) @(negedge clk);
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ flip_par);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic key(input logic [7:0] code, input logic [5:0] keys);
    sb.push_back('{is_err: 1'b0, code: code, keys: keys, lat: LAT});
    send_frame(code, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h", name, got, want);
    end
  endtask

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  // keys order: {up, down, left, right, enter, fire}
  initial begin : stim
    int waited;
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {14'd0, keys_now(), scan_valid, frame_err, scan_code}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    key(8'h5A, 6'b000010);
    key(8'hF0, 6'b000010);
    key(8'h5A, 6'b000000);

    key(8'hE0, 6'b000000);
    key(8'h75, 6'b100000);
    key(8'hE0, 6'b100000);
    key(8'h6B, 6'b101000);
    key(8'hE0, 6'b101000);
    key(8'hF0, 6'b101000);
    key(8'h75, 6'b001000);

    sb.push_back('{is_err: 1'b1, code: 8'h00, keys: 6'b001000, lat: LAT});
    send_frame(8'h29, 1'b1);
    check("fire_after_bad_parity", {31'd0, fire}, 32'd0);

    // E0 then a truncated frame: the timeout must also drop the pending E0.
    key(8'hE0, 6'b001000);
    sb.push_back('{is_err: 1'b1, code: 8'h00, keys: 6'b001000, lat: LAT + T});
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    ps2_data = 1'b1;
    repeat (T + 20) @(negedge clk);
    key(8'h72, 6'b001000);

    // Reset while bit 5 of a frame is on the bus.
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    repeat (H) @(negedge clk);
    ps2_data = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check("outputs_after_midframe_rst", {14'd0, keys_now(), scan_valid, frame_err, scan_code}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    key(8'hE0, 6'b000000);
    key(8'h72, 6'b010000);
    key(8'h75, 6'b010000);
    key(8'h29, 6'b010001);
    key(8'h29, 6'b010001);

    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("scoreboard_drained", sb.size(), 32'd0);
    check("final_keys", {26'd0, keys_now()}, 32'b010001);
    check("final_scan_code", {24'd0, scan_code}, 32'h29);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
